// File: rtl/fetch_stage_pkg.sv
// Shared types and sizes for the instruction-fetch stage.
// Optional perf counters in fetch_stage are enabled with FETCH_PERF_CNT_EN.
package fetch_stage_pkg;

    localparam int N             = 32;
    localparam int INST_MEM_SIZE = 256;
    localparam int MEM_CELL_SIZE = 8;

    localparam logic [N-1:0] WORD_BYTES    = N'(N / MEM_CELL_SIZE);
    localparam logic [N-1:0] INST_MEM_LAST = N'(INST_MEM_SIZE - (N / MEM_CELL_SIZE));

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic         valid;
        logic [N-1:0] instr;
        logic [N-1:0] pc;
        logic [N-1:0] pc4;
    } if_id_t;

    // A fetch is legal only for a word-aligned address that lies fully inside memory.
    function automatic logic fetch_legal(input logic [N-1:0] pc);
        return (pc[1:0] == 2'b00) && (pc <= INST_MEM_LAST);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: hazard/redirect inputs, instruction memory port,
// IF/ID outputs, fault report and FSM state for observation.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    // if_id_valid_o qualifies the IF/ID fields; there is no ready, stall_i is the
    // only back-pressure and holds everything while high.
    logic         stall_i;
    logic         redirect_i;
    logic [N-1:0] redirect_pc_i;
    logic [N-1:0] imem_addr_o;
    logic [N-1:0] imem_instr_i;
    logic         if_id_valid_o;
    logic [N-1:0] if_id_instr_o;
    logic [N-1:0] if_id_pc_o;
    logic [N-1:0] if_id_pc4_o;
    logic         fault_o;
    logic [N-1:0] fault_pc_o;
    fetch_state_t state_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_instr_i,
        output imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o,
               fault_o, fault_pc_o, state_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_instr_i,
        input  imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o,
               fault_o, fault_pc_o, state_o
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with next-PC select and fetch legality check.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         halt_i,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [N-1:0] redirect_pc_i,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] pc_plus4_o,
    output logic         legal_o
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + WORD_BYTES;
    assign legal_o    = fetch_legal(pc_q);

    // Redirect targets are taken unchecked; an illegal target faults once it is the PC.
    always_comb begin
        pc_d = pc_q;
        if (halt_i) begin
            pc_d = pc_q;
        end else if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (stall_i || !legal_o) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: RUN/HALT FSM, IF/ID pipeline register and fault capture.
// Define FETCH_PERF_CNT_EN to add saturating fetch/bubble counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_stage_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       bubble_cnt_o
`endif
);

    fetch_state_t state_q, state_d;
    if_id_t       if_id_q, if_id_d;
    logic         fault_q, fault_d;
    logic [N-1:0] fault_pc_q, fault_pc_d;

    logic [N-1:0] pc;
    logic [N-1:0] pc_plus4;
    logic         legal;
    logic         load;
    logic         bubble;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .halt_i        (state_q == HALT),
        .stall_i       (bus.stall_i),
        .redirect_i    (bus.redirect_i),
        .redirect_pc_i (bus.redirect_pc_i),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .legal_o       (legal)
    );

    // In HALT everything holds; redirect beats stall, stall beats the legality check.
    always_comb begin
        state_d    = state_q;
        if_id_d    = if_id_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        load       = 1'b0;
        bubble     = 1'b0;
        if (state_q == RUN) begin
            if (bus.redirect_i) begin
                if_id_d.valid = 1'b0;
                bubble        = 1'b1;
            end else if (bus.stall_i) begin
                bubble = 1'b1;
            end else if (!legal) begin
                state_d       = HALT;
                fault_d       = 1'b1;
                fault_pc_d    = pc;
                if_id_d.valid = 1'b0;
                bubble        = 1'b1;
            end else begin
                if_id_d.valid = 1'b1;
                if_id_d.instr = bus.imem_instr_i;
                if_id_d.pc    = pc;
                if_id_d.pc4   = pc_plus4;
                load          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            if_id_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            if_id_q    <= if_id_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign bus.imem_addr_o   = pc;
    assign bus.if_id_valid_o = if_id_q.valid;
    assign bus.if_id_instr_o = if_id_q.instr;
    assign bus.if_id_pc_o    = if_id_q.pc;
    assign bus.if_id_pc4_o   = if_id_q.pc4;
    assign bus.fault_o       = fault_q;
    assign bus.fault_pc_o    = fault_pc_q;
    assign bus.state_o       = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    logic unused_load_bubble;
    assign unused_load_bubble = load ^ bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/reset traffic,
// checked against a cycle-level transaction model through expected queues.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o  (fetch_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    // ---------------- instruction memory (byte cells, big-endian words) ----------------
    logic [7:0] mem [INST_MEM_SIZE];
    logic [7:0] a8;
    assign a8 = bus.imem_addr_o[7:0];
    assign bus.imem_instr_i = (bus.imem_addr_o <= 32'(INST_MEM_SIZE - 4))
                              ? {mem[a8], mem[a8 + 8'd1], mem[a8 + 8'd2], mem[a8 + 8'd3]}
                              : 32'hDEAD_BEEF;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int i;
        i = int'(a);
        return {mem[i], mem[i + 1], mem[i + 2], mem[i + 3]};
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_valid;
    bit          m_fault;
    logic [31:0] m_fault_pc;
    logic [31:0] m_fetch_n;
    logic [31:0] m_bubble_n;

    logic [95:0] fetch_q[$];   // {instr, pc, pc4} per newly loaded instruction
    logic [66:0] stat_q[$];    // {imem_addr, valid, fault, fault_pc, halted} per edge
    logic [63:0] perf_q[$];    // {fetch count, bubble count} per edge

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances by the same edge and records expectations.
    task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
        @(negedge clk);
        rst               = r;
        bus.stall_i       = s;
        bus.redirect_i    = d;
        bus.redirect_pc_i = t;
        if (r) begin
            m_pc = 32'h0; m_halt = 0; m_valid = 0; m_fault = 0; m_fault_pc = 32'h0;
            m_fetch_n = 0; m_bubble_n = 0;
        end else if (!m_halt) begin
            if (d) begin
                m_pc = t; m_valid = 0; m_bubble_n++;
            end else if (s) begin
                m_bubble_n++;
            end else if (m_pc % 4 != 0 || m_pc > INST_MEM_SIZE - 4) begin
                m_halt = 1; m_fault = 1; m_fault_pc = m_pc; m_valid = 0; m_bubble_n++;
            end else begin
                fetch_q.push_back({word_at(m_pc), m_pc, m_pc + 32'd4});
                m_valid = 1; m_pc = m_pc + 32'd4; m_fetch_n++;
            end
        end
        stat_q.push_back({m_pc, m_valid, m_fault, m_fault_pc, m_halt});
        perf_q.push_back({m_fetch_n, m_bubble_n});
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [66:0] e;
        logic [95:0] f;
        logic [63:0] p;
        bit s_stall, s_rst;
        forever begin
            @(posedge clk);
            s_stall = bus.stall_i;
            s_rst   = rst;
            #1;
            if (stat_q.size() > 0) begin
                e = stat_q.pop_front();
                p = perf_q.pop_front();
                chk("imem_addr", bus.imem_addr_o, e[66:35]);
                chk("valid", 32'(bus.if_id_valid_o), 32'(e[34]));
                chk("fault", 32'(bus.fault_o), 32'(e[33]));
                chk("fault_pc", bus.fault_pc_o, e[32:1]);
                chk("state_halt", 32'(bus.state_o == HALT), 32'(e[0]));
`ifdef FETCH_PERF_CNT_EN
                chk("fetch_cnt", fetch_cnt, p[63:32]);
                chk("bubble_cnt", bubble_cnt, p[31:0]);
`endif
                if (s_rst) begin
                    chk("rst_instr", bus.if_id_instr_o, 32'h0);
                    chk("rst_pc", bus.if_id_pc_o, 32'h0);
                    chk("rst_pc4", bus.if_id_pc4_o, 32'h0);
                end else if (bus.if_id_valid_o && !s_stall) begin
                    if (fetch_q.size() == 0) begin
                        chk("unexpected_fetch", bus.if_id_pc_o, 32'hFFFF_FFFF);
                    end else begin
                        f = fetch_q.pop_front();
                        chk("if_id_instr", bus.if_id_instr_o, f[95:64]);
                        chk("if_id_pc", bus.if_id_pc_o, f[63:32]);
                        chk("if_id_pc4", bus.if_id_pc4_o, f[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] tgt;
        bus.stall_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0;
        for (int i = 0; i < INST_MEM_SIZE; i++) mem[i] = 8'($urandom);
        {mem[0], mem[1], mem[2], mem[3]} = 32'h8001_000A;
        {mem[4], mem[5], mem[6], mem[7]} = 32'h0401_1800;

        // reset, free run, 3-cycle stall holding pc=4
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        // redirect wins over stall
        step(0, 1, 1, 32'h10); step(0, 0, 0, 0); step(0, 0, 0, 0);
        // misaligned target faults, later redirect ignored, reset recovers
        step(0, 0, 1, 32'h6); step(0, 0, 0, 0); step(0, 1, 1, 32'h0);
        step(0, 0, 1, 32'h0); step(0, 0, 0, 0);
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        // sequential fetch through the last word into the range fault
        step(1, 0, 0, 0);
        repeat (INST_MEM_SIZE / 4 + 3) step(0, 0, 0, 0);
        // reset one cycle after a redirect
        step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 32'h20); step(1, 0, 0, 0); step(0, 0, 0, 0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 9))
                0:       tgt = $urandom;
                1:       tgt = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                2:       tgt = 32'(INST_MEM_SIZE) + 32'($urandom_range(0, 3) * 4);
                default: tgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            step(($urandom_range(0, 60) == 0) || (m_halt && ($urandom_range(0, 3) == 0)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, tgt);
        end
        step(0, 0, 0, 0);

        @(posedge clk);
        #2;
        chk("stat_q_drained", 32'(stat_q.size()), 32'd0);
        chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the program counter, drives the byte address into the combinational instruction memory, and registers the returned 32-bit word into the IF/ID pipeline register for decode. It sits directly upstream of the instruction memory, which it addresses, and directly upstream of decode, which consumes its IF/ID outputs. It honours hazard stalls and EX-stage branch/jump redirects, and halts with a fault on an illegal fetch address.

## Interface
- RESET_PC, 0: PC value loaded on reset; must be a multiple of 4.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall_i  in  1  hazard unit: hold PC and IF/ID contents.
- redirect_i  in  1  EX stage: taken branch/jump this cycle.
- redirect_pc_i  in  N  redirect target byte address.
- imem_addr_o  out  N  byte address to instruction memory; equals current PC.
- imem_instr_i  in  N  big-endian word from instruction memory, valid in the same cycle.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_instr_o  out  N  fetched instruction.
- if_id_pc_o  out  N  address of if_id_instr_o.
- if_id_pc4_o  out  N  if_id_pc_o + 4.
- fault_o  out  1  sticky illegal-fetch flag.
- fault_pc_o  out  N  PC that caused the fault.

## Operation
- State machine, two states: RUN and HALT. Reset enters RUN.
- Fetch is legal when pc[1:0]==0 and pc <= INST_MEM_SIZE-4.
- RUN, per edge, in priority order:
  - rst: PC=RESET_PC, IF/ID cleared, fault cleared.
  - redirect_i: PC=redirect_pc_i; IF/ID valid=0 (flush). Redirect wins over stall_i.
  - stall_i: PC and all IF/ID registers hold.
  - Illegal PC: go to HALT; fault_o=1; fault_pc_o=PC; IF/ID valid=0; PC holds.
  - Otherwise: IF/ID takes {imem_instr_i, PC, PC+4} with valid=1, and PC=PC+4.
- HALT: PC and IF/ID hold, valid=0, and redirect and stall are ignored. Only rst leaves HALT.
- Arithmetic: PC+4 is computed modulo 2^N. There is no separate wrap handling; the range check catches the out-of-range address.
- Redirect targets are not checked when accepted. An illegal target faults on the following edge, when it becomes the PC.

## Timing
- Reset values: imem_addr_o=RESET_PC, if_id_valid_o=0, if_id_instr_o=0, if_id_pc_o=0, if_id_pc4_o=0, fault_o=0, fault_pc_o=0.
- imem_addr_o is a register output. Memory read is combinational, so the instruction at PC appears on if_id_instr_o one cycle after PC is presented.
- First valid instruction appears the cycle after rst deasserts.
- Redirect penalty: one bubble. The cycle after a redirect, valid=0 and imem_addr_o=target; the target instruction is valid one cycle later.
- A stall held for k cycles adds exactly k cycles, with no instruction lost or duplicated.
- rst asserted mid-operation, including in HALT, takes effect at the next edge regardless of other inputs.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two outputs, fetch_cnt_o and bubble_cnt_o, each 32 bits, cleared by rst.
  - fetch_cnt_o increments on every edge that loads a valid instruction.
  - bubble_cnt_o increments on every RUN edge where IF/ID ends invalid or stalled.
  - Both saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package defines:
  - fetch_state_t enum {RUN, HALT}.
  - if_id_t packed struct {valid, instr, pc, pc4}.
  - These sit alongside the existing N, INST_MEM_SIZE and MEM_CELL_SIZE.
- One sub-module, pc_reg: holds the PC register, next-PC select (reset/redirect/stall/increment) and the legality check.
- fetch_stage holds the FSM and the IF/ID register.

## Test plan
- Reset, then free-run with memory preloaded with 0x8001000A at address 0 and 0x04011800 at address 4:
  - cycle 1: valid=1, instr=0x8001000A, pc=0, pc4=4.
  - cycle 2: instr=0x04011800, pc=4.
- stall_i high for 3 cycles while IF/ID holds pc=4: outputs frozen for 3 cycles, imem_addr_o stays 8, then pc=8 follows with no gaps.
- redirect_i with target 0x10 while stall_i=1: next cycle valid=0 and imem_addr_o=0x10; following cycle pc=0x10, valid=1.
- Redirect to 0x6 (misaligned): one cycle later fault_o=1, fault_pc_o=0x6, valid=0. Subsequent redirect to 0 is ignored; rst recovers to pc=0.
- Sequential fetch up to INST_MEM_SIZE-4: last word valid, then fault_pc_o=INST_MEM_SIZE. With FETCH_PERF_CNT_EN, fetch_cnt_o=INST_MEM_SIZE/4.
- rst asserted one cycle after a redirect: next edge all outputs at reset values and imem_addr_o=RESET_PC.
